// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - handshake, data and forwarding buses around the memory stage
interface mem_stage_if;
  logic         exe_to_mem_valid;
  logic         mem_allowin;
  logic [145:0] exe_to_mem_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_bus;
  logic [38:0]  mem_rf_bus;
  logic         mem_ex;

  // Pipeline / memory / writeback side that feeds the stage.
  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, data_sram_data_ok, data_sram_rdata,
           flush, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_rf_bus, mem_ex
  );

  // The memory stage itself.
  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, data_sram_data_ok, data_sram_rdata,
           flush, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_rf_bus, mem_ex
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: load response capture/drop, load and multiply result select
module mem_stage (
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave mif
);
  localparam int BUS_W = 146;

  logic [BUS_W-1:0] bus_q, bus_d;
  logic             mem_valid_q, mem_valid_d;
  logic             buf_valid_q, buf_valid_d;
  logic             drop_q, drop_d;
  logic [31:0]      rdata_buf_q, rdata_buf_d;

  // Field view of the captured instruction.
  logic [31:0] pc;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result;
  logic [1:0]  addr_lo;
  logic [4:0]  load_op;
  logic        rfrom_mem;
  logic [2:0]  mul_op;
  logic [63:0] mul_result;
  logic        ex_in;

  assign {pc, gr_we, dest, exe_result, addr_lo, load_op, rfrom_mem,
          mul_op, mul_result, ex_in} = bus_q;

  logic need_resp, resp_ok, mem_ready_go, mem_allowin, leave;
  logic [31:0] load_word, load_data, final_result;
  logic [15:0] half;
  logic [7:0]  byte_sel;

  // A faulting load never issued a request, so it does not wait for one.
  assign need_resp    = rfrom_mem & ~ex_in;
  // A response owed to a flushed load is swallowed, never used.
  assign resp_ok      = mif.data_sram_data_ok & ~drop_q;
  assign mem_ready_go = ~need_resp | buf_valid_q | resp_ok;
  assign mem_allowin  = ~mem_valid_q | (mem_ready_go & mif.wb_allowin);
  assign leave        = mem_valid_q & mem_ready_go & mif.wb_allowin;

  // Load alignment/extension; a live response bypasses the buffer.
  always_comb begin
    load_word = buf_valid_q ? rdata_buf_q : mif.data_sram_rdata;
    half      = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (addr_lo)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    if (load_op[4])      load_data = load_word;
    else if (load_op[3]) load_data = {{16{half[15]}}, half};
    else if (load_op[2]) load_data = {16'h0, half};
    else if (load_op[1]) load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (load_op[0]) load_data = {24'h0, byte_sel};
    else                 load_data = 32'h0;
  end

  // Result priority: load data, then multiply, then ALU.
  always_comb begin
    if (rfrom_mem)      final_result = load_data;
    else if (|mul_op)   final_result = mul_op[2] ? mul_result[31:0] : mul_result[63:32];
    else                final_result = exe_result;
  end

  // Next-state: stage occupancy, bus capture, response buffer and drop tracking.
  always_comb begin
    mem_valid_d = mem_valid_q;
    if (mif.flush)        mem_valid_d = 1'b0;
    else if (mem_allowin) mem_valid_d = mif.exe_to_mem_valid;

    bus_d = (mif.exe_to_mem_valid & mem_allowin) ? mif.exe_to_mem_bus : bus_q;

    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    if (leave | mif.flush) begin
      buf_valid_d = 1'b0;
    end else if (mem_valid_q & need_resp & resp_ok) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = mif.data_sram_rdata;
    end

    drop_d = drop_q;
    if (mif.flush & mem_valid_q & need_resp & ~buf_valid_q & ~mif.data_sram_data_ok)
      drop_d = 1'b1;
    else if (mif.data_sram_data_ok)
      drop_d = 1'b0;
  end

  // State registers; reset abandons any outstanding response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_q       <= '0;
      mem_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      rdata_buf_q <= 32'h0;
    end else begin
      bus_q       <= bus_d;
      mem_valid_q <= mem_valid_d;
      buf_valid_q <= buf_valid_d;
      drop_q      <= drop_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign mif.mem_allowin     = mem_allowin;
  assign mif.mem_to_wb_valid = mem_valid_q & mem_ready_go;
  assign mif.mem_to_wb_bus   = {pc, gr_we, dest, final_result};
  assign mif.mem_ex          = mem_valid_q & ex_in;
  // Forwarding bus is held at zero while reset is asserted.
  assign mif.mem_rf_bus      = resetn ?
                               {dest & {5{gr_we & mem_valid_q}}, final_result, mem_valid_q, mem_ready_go} :
                               39'h0;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized and directed self-checking bench for mem_stage
module tb_mem_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] exe;
    logic [1:0]  addr;
    logic [4:0]  lop;
    logic        rfrom;
    logic [2:0]  mop;
    logic [63:0] mul;
    logic        ex;
  } instr_t;

  logic clk;
  logic resetn;
  mem_stage_if mif();

  mem_stage dut (.clk(clk), .resetn(resetn), .mif(mif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus for the current cycle
  instr_t      in_instr;
  logic        in_valid, in_flush, in_wb, in_dok;
  logic [31:0] in_rdata;

  // behavioural model
  logic        m_valid;
  instr_t      m_ins;
  logic        m_have;
  logic [31:0] m_word;
  int          m_discard;
  int          owed;
  logic        m_needs, m_ready, m_out_valid, m_allowin;
  logic [31:0] m_result;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [145:0] act, input logic [145:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_val(input instr_t i, input logic [31:0] w);
    logic [31:0] h, b;
    h = (w >> (16 * i.addr[1])) & 32'hFFFF;
    b = (w >> (8 * i.addr)) & 32'hFF;
    case (i.lop)
      5'b10000: return w;
      5'b01000: return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      5'b00100: return h;
      5'b00010: return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      default:  return b;
    endcase
  endfunction

  function automatic logic [31:0] result_of(input instr_t i, input logic [31:0] w);
    if (i.rfrom)           return ld_val(i, w);
    else if (i.mop != 3'b0) return (i.mop == 3'b100) ? i.mul[31:0] : i.mul[63:32];
    else                   return i.exe;
  endfunction

  function automatic instr_t mk(input logic [31:0] exe, input logic [4:0] lop, input logic [1:0] addr,
                                input logic [2:0] mop, input logic [63:0] mul, input logic ex);
    instr_t i;
    i.pc    = $urandom;
    i.we    = 1'b1;
    i.dest  = 5'($urandom_range(1, 31));
    i.exe   = exe;
    i.addr  = addr;
    i.lop   = lop;
    i.rfrom = (lop != 5'b0);
    i.mop   = mop;
    i.mul   = mul;
    i.ex    = ex;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 9);
    i = mk($urandom, 5'b0, 2'($urandom), 3'b0, {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
    i.we = 1'($urandom);
    if (k < 5) begin
      i.lop   = 5'(1 << k);
      i.rfrom = 1'b1;
    end else if (k < 8) begin
      i.mop = 3'(1 << (k - 5));
    end
    return i;
  endfunction

  // drive inputs after the falling edge, then compare DUT against the model
  task automatic settle();
    @(negedge clk);
    mif.exe_to_mem_valid  = in_valid;
    mif.exe_to_mem_bus    = in_instr;
    mif.flush             = in_flush;
    mif.wb_allowin        = in_wb;
    mif.data_sram_data_ok = in_dok;
    mif.data_sram_rdata   = in_rdata;
    #1;
    m_needs     = m_ins.rfrom && !m_ins.ex;
    m_ready     = !m_needs || m_have || (in_dok && m_discard == 0);
    m_out_valid = m_valid && m_ready;
    m_allowin   = !m_valid || (m_ready && in_wb);
    m_result    = result_of(m_ins, m_have ? m_word : in_rdata);
    chk("allowin", mif.mem_allowin, m_allowin);
    chk("to_wb_valid", mif.mem_to_wb_valid, m_out_valid);
    if (m_out_valid) chk("to_wb_bus", mif.mem_to_wb_bus, {m_ins.pc, m_ins.we, m_ins.dest, m_result});
    chk("mem_ex", mif.mem_ex, m_valid && m_ins.ex);
    chk("fwd_dest", mif.mem_rf_bus[38:34], (m_valid && m_ins.we) ? m_ins.dest : 5'd0);
    chk("rf_valid", mif.mem_rf_bus[1], m_valid);
    if (m_valid) begin
      chk("rf_result", mif.mem_rf_bus[33:2], m_result);
      chk("rf_ready", mif.mem_rf_bus[0], m_ready);
    end
  endtask

  // advance the model across the rising edge
  task automatic tick();
    logic leave, waiting;
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0; m_have = 1'b0; m_discard = 0; m_ins = '0;
      return;
    end
    leave   = m_out_valid && in_wb;
    waiting = m_valid && m_needs && !m_have;
    if (in_dok) begin
      owed--;
      if (m_discard > 0) m_discard--;
      else if (waiting && !leave && !in_flush) begin
        m_have = 1'b1;
        m_word = in_rdata;
      end
    end else if (in_flush && waiting) begin
      m_discard++;
    end
    if (leave || in_flush) m_have = 1'b0;
    if (in_flush) m_valid = 1'b0;
    else if (m_allowin) begin
      m_valid = in_valid;
      if (in_valid) begin
        m_ins  = in_instr;
        m_have = 1'b0;
        if (in_instr.rfrom && !in_instr.ex) owed++;
      end
    end
  endtask

  task automatic offer(input instr_t i);
    in_valid = 1'b1;
    in_instr = i;
    settle();
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    in_instr = '0; in_valid = 0; in_flush = 0; in_wb = 1; in_dok = 0; in_rdata = 0;
    m_valid = 0; m_ins = '0; m_have = 0; m_word = 0; m_discard = 0; owed = 0;
    mif.exe_to_mem_valid = 0; mif.exe_to_mem_bus = '0; mif.flush = 0;
    mif.wb_allowin = 1; mif.data_sram_data_ok = 0; mif.data_sram_rdata = 0;
    #2;
    chk("rst_allowin", mif.mem_allowin, 1'b1);
    chk("rst_to_wb_valid", mif.mem_to_wb_valid, 1'b0);
    chk("rst_mem_ex", mif.mem_ex, 1'b0);
    chk("rst_rf_bus", mif.mem_rf_bus, 39'h0);
    tick(); tick();
    #2 resetn = 1'b1;

    // ALU op completes in its entry cycle
    offer(mk(32'h1234_5678, 5'b0, 2'd0, 3'b0, 64'h0, 1'b0));
    settle();
    chk("alu_valid", mif.mem_to_wb_valid, 1'b1);
    chk("alu_result", mif.mem_to_wb_bus[31:0], 32'h1234_5678);
    tick();

    // LD_B addr 3, response two cycles after entry
    offer(mk(32'h0, 5'b00010, 2'd3, 3'b0, 64'h0, 1'b0));
    settle();
    chk("ldb_wait", mif.mem_to_wb_valid, 1'b0);
    tick();
    settle(); tick();
    in_dok = 1; in_rdata = 32'h80FF_0000;
    settle();
    chk("ldb_valid", mif.mem_to_wb_valid, 1'b1);
    chk("ldb_result", mif.mem_to_wb_bus[31:0], 32'hFFFF_FF80);
    tick();
    in_dok = 0;
    offer(mk(32'h0, 5'b00001, 2'd3, 3'b0, 64'h0, 1'b0));
    in_dok = 1;
    settle();
    chk("ldbu_result", mif.mem_to_wb_bus[31:0], 32'h0000_0080);
    tick();
    in_dok = 0;

    // LD_HU addr 2, response buffered while writeback stalls
    offer(mk(32'h0, 5'b00100, 2'd2, 3'b0, 64'h0, 1'b0));
    in_wb = 0; in_dok = 1; in_rdata = 32'hBEEF_0001;
    settle();
    chk("ldhu_allowin0", mif.mem_allowin, 1'b0);
    tick();
    in_dok = 0; in_rdata = 32'h1111_1111;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("ldhu_hold_allowin", mif.mem_allowin, 1'b0);
      chk("ldhu_hold_result", mif.mem_to_wb_bus[31:0], 32'h0000_BEEF);
      tick();
    end
    in_wb = 1;
    settle();
    chk("ldhu_exit_valid", mif.mem_to_wb_valid, 1'b1);
    chk("ldhu_exit_result", mif.mem_to_wb_bus[31:0], 32'h0000_BEEF);
    chk("ldhu_exit_allowin", mif.mem_allowin, 1'b1);
    tick();

    // flushed load: its late response is dropped, next load gets the second one
    offer(mk(32'h0, 5'b10000, 2'd0, 3'b0, 64'h0, 1'b0));
    settle(); tick();
    in_flush = 1;
    settle(); tick();
    in_flush = 0;
    offer(mk(32'h0, 5'b10000, 2'd0, 3'b0, 64'h0, 1'b0));
    in_dok = 1; in_rdata = 32'hDEAD_DEAD;
    settle();
    chk("drop_first", mif.mem_to_wb_valid, 1'b0);
    tick();
    in_rdata = 32'h0000_0042;
    settle();
    chk("drop_second_valid", mif.mem_to_wb_valid, 1'b1);
    chk("drop_second_result", mif.mem_to_wb_bus[31:0], 32'h0000_0042);
    tick();
    in_dok = 0;

    // multiply selects
    offer(mk(32'hAAAA_AAAA, 5'b0, 2'd0, 3'b001, 64'h0000_0003_0000_0001, 1'b0));
    settle();
    chk("mulhwu_result", mif.mem_to_wb_bus[31:0], 32'h0000_0003);
    tick();
    offer(mk(32'hAAAA_AAAA, 5'b0, 2'd0, 3'b100, 64'h0000_0003_0000_0001, 1'b0));
    settle();
    chk("mulw_result", mif.mem_to_wb_bus[31:0], 32'h0000_0001);
    tick();

    // faulting load completes at once
    offer(mk(32'h0, 5'b10000, 2'd0, 3'b0, 64'h0, 1'b1));
    settle();
    chk("exload_valid", mif.mem_to_wb_valid, 1'b1);
    chk("exload_mem_ex", mif.mem_ex, 1'b1);
    tick();

    // asynchronous reset while a load waits
    offer(mk(32'h0, 5'b10000, 2'd0, 3'b0, 64'h0, 1'b0));
    settle(); tick();
    settle();
    #1 resetn = 1'b0;
    #1;
    chk("async_allowin", mif.mem_allowin, 1'b1);
    chk("async_to_wb_valid", mif.mem_to_wb_valid, 1'b0);
    chk("async_mem_ex", mif.mem_ex, 1'b0);
    chk("async_rf_bus", mif.mem_rf_bus, 39'h0);
    tick();
    #2 resetn = 1'b1;
    in_dok = 1; in_rdata = 32'h0000_0055;
    settle();
    chk("stale_ignored", mif.mem_to_wb_valid, 1'b0);
    tick();
    in_dok = 0;
    offer(mk(32'h0, 5'b10000, 2'd0, 3'b0, 64'h0, 1'b0));
    settle();
    chk("post_rst_wait", mif.mem_to_wb_valid, 1'b0);
    tick();
    in_dok = 1; in_rdata = 32'h0000_0077;
    settle();
    chk("post_rst_result", mif.mem_to_wb_bus[31:0], 32'h0000_0077);
    tick();
    in_dok = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_wb    = ($urandom_range(0, 3) != 0);
      in_flush = (m_discard == 0) && ($urandom_range(0, 11) == 0);
      in_valid = !in_flush && ($urandom_range(0, 1) == 1);
      in_instr = rand_instr();
      in_dok   = (owed > 0) && ($urandom_range(0, 2) == 0);
      in_rdata = $urandom;
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
